// File: rtl/sale_terminal_if.sv
// sale_terminal_if: groups the control FSM's command/status signals.
// "master" is the FSM side (drives commands); "slave" is the side facing
// the conditioners and the barcode/direction/basket controllers.
interface sale_terminal_if #(
    parameter int NUM_KEYS = 4,
    parameter int DIGIT_W  = 4,
    parameter int PID_W    = 4,
    parameter int CNT_W    = 4
) ();
    logic [NUM_KEYS-1:0] key_pulse;
    logic                sel_pulse;
    logic                sw_interactive;
    logic                sw_edit;
    logic                barcode_done;
    logic                barcode_valid;
    logic [PID_W-1:0]    barcode_pid;
    logic [PID_W-1:0]    dir_pid;
    logic [CNT_W-1:0]    basket_count;
    logic [2:0]          state;
    logic                barcode_push;
    logic [DIGIT_W-1:0]  digit_out;
    logic                barcode_clr;
    logic                dir_push;
    logic [1:0]          dir_out;
    logic                basket_add;
    logic                basket_del;
    logic [PID_W-1:0]    pid_out;
    logic [DIGIT_W-1:0]  qty_out;
    logic                err;

    modport master (
        input  key_pulse, sel_pulse, sw_interactive, sw_edit,
               barcode_done, barcode_valid, barcode_pid, dir_pid, basket_count,
        output state, barcode_push, digit_out, barcode_clr, dir_push, dir_out,
               basket_add, basket_del, pid_out, qty_out, err
    );

    modport slave (
        output key_pulse, sel_pulse, sw_interactive, sw_edit,
               barcode_done, barcode_valid, barcode_pid, dir_pid, basket_count,
        input  state, barcode_push, digit_out, barcode_clr, dir_push, dir_out,
               basket_add, basket_del, pid_out, qty_out, err
    );
endinterface

// File: rtl/sale_terminal_fsm.sv
// sale_terminal_fsm: top-level control FSM of the sale terminal.
// Sequences barcode entry, interactive selection, quantity entry, basket
// edit and end-of-shopping. Every output is registered; command outputs
// are single-cycle pulses.
// Optional: define SALE_FSM_QTY_TIMEOUT_EN to abort quantity entry after
// QTY_TIMEOUT idle cycles.
module sale_terminal_fsm #(
    parameter int NUM_KEYS     = 4,
    parameter int DIGIT_W      = 4,
    parameter int PID_W        = 4,
    parameter int BASKET_DEPTH = 8,
    parameter int MAX_QTY      = 9,
    parameter int ERR_HOLD     = 50000000,
    parameter int QTY_TIMEOUT  = 500000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    sale_terminal_if.master  bus
);
    localparam int CNT_W = $clog2(BASKET_DEPTH + 1);
    localparam int ERR_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_IDLE    = 3'd1,
        S_BARCODE = 3'd2,
        S_INTER   = 3'd3,
        S_QTY     = 3'd4,
        S_EDIT    = 3'd5,
        S_ERROR   = 3'd6,
        S_END     = 3'd7
    } state_t;

    state_t             st;
    logic               barcode_push_q, barcode_clr_q, dir_push_q;
    logic               basket_add_q, basket_del_q, err_q;
    logic [DIGIT_W-1:0] digit_q, qty_q, acc;
    logic [1:0]         dir_q;
    logic [PID_W-1:0]   pid_q;
    logic [ERR_W-1:0]   err_cnt;
    logic [2:0]         key_idx;
    logic               key_any;
    logic               basket_full;

`ifdef SALE_FSM_QTY_TIMEOUT_EN
    localparam int TMO_W = $clog2(QTY_TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_cnt;
`else
    logic unused_qty_timeout;
    assign unused_qty_timeout = (QTY_TIMEOUT > 0);
`endif

    // Accumulate a quantity key, saturating at MAX_QTY.
    function automatic logic [DIGIT_W-1:0] qty_sat_add(input logic [DIGIT_W-1:0] a,
                                                       input logic [2:0] idx);
        int sum;
        sum = int'(a) + int'(idx) + 1;
        if (sum > MAX_QTY) sum = MAX_QTY;
        return DIGIT_W'(sum);
    endfunction

    // Lowest set key bit wins.
    always_comb begin
        key_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (bus.key_pulse[i]) key_idx = 3'(i);
        end
    end

    assign key_any     = |bus.key_pulse;
    assign basket_full = (bus.basket_count >= CNT_W'(BASKET_DEPTH));

    // State register plus all registered outputs; pulses default low each cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st             <= S_START;
            barcode_push_q <= 1'b0;
            barcode_clr_q  <= 1'b0;
            dir_push_q     <= 1'b0;
            basket_add_q   <= 1'b0;
            basket_del_q   <= 1'b0;
            err_q          <= 1'b0;
            digit_q        <= '0;
            qty_q          <= '0;
            acc            <= '0;
            dir_q          <= '0;
            pid_q          <= '0;
            err_cnt        <= '0;
`ifdef SALE_FSM_QTY_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            barcode_push_q <= 1'b0;
            barcode_clr_q  <= 1'b0;
            dir_push_q     <= 1'b0;
            basket_add_q   <= 1'b0;
            basket_del_q   <= 1'b0;
            case (st)
                S_START: begin
                    barcode_clr_q <= 1'b1;
                    st            <= S_IDLE;
                end
                S_IDLE: begin
                    if (bus.sel_pulse) begin
                        st <= S_END;
                    end else if (bus.sw_edit) begin
                        barcode_clr_q <= 1'b1;
                        st            <= S_EDIT;
                    end else if (bus.sw_interactive) begin
                        barcode_clr_q <= 1'b1;
                        st            <= S_INTER;
                    end else begin
                        st <= S_BARCODE;
                    end
                end
                S_BARCODE: begin
                    if (bus.sw_interactive || bus.sw_edit) begin
                        st <= S_IDLE;
                    end else if (!bus.barcode_done) begin
                        if (key_any) begin
                            barcode_push_q <= 1'b1;
                            digit_q        <= DIGIT_W'(NUM_KEYS - int'(key_idx));
                        end
                    end else if (bus.sel_pulse) begin
                        barcode_clr_q <= 1'b1;
                        if (bus.barcode_valid) begin
                            pid_q <= bus.barcode_pid;
                            acc   <= '0;
`ifdef SALE_FSM_QTY_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                            st    <= S_QTY;
                        end else begin
                            err_q   <= 1'b1;
                            err_cnt <= ERR_W'(ERR_HOLD - 1);
                            st      <= S_ERROR;
                        end
                    end
                end
                S_INTER: begin
                    if (!bus.sw_interactive) begin
                        st <= S_IDLE;
                    end else if (bus.sel_pulse) begin
                        pid_q <= bus.dir_pid;
                        acc   <= '0;
`ifdef SALE_FSM_QTY_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        st    <= S_QTY;
                    end else if (key_any && key_idx < 3'd4) begin
                        dir_push_q <= 1'b1;
                        dir_q      <= 2'(3 - int'(key_idx));
                    end
                end
                S_QTY: begin
`ifdef SALE_FSM_QTY_TIMEOUT_EN
                    if (key_any || bus.sel_pulse) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_W'(QTY_TIMEOUT - 1)) begin
                        barcode_clr_q <= 1'b1;
                        st            <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                    if (bus.sel_pulse) begin
                        if (acc != '0) begin
                            if (basket_full) begin
                                err_q   <= 1'b1;
                                err_cnt <= ERR_W'(ERR_HOLD - 1);
                                st      <= S_ERROR;
                            end else begin
                                qty_q        <= acc;
                                basket_add_q <= 1'b1;
                                st           <= S_IDLE;
                            end
                        end
                    end else if (key_any) begin
                        acc <= qty_sat_add(acc, key_idx);
                    end
                end
                S_EDIT: begin
                    if (!bus.sw_edit) begin
                        st <= S_IDLE;
                    end else if (bus.sel_pulse) begin
                        if (bus.basket_count != '0) basket_del_q <= 1'b1;
                    end else if (key_any && key_idx < 3'd4) begin
                        dir_push_q <= 1'b1;
                        dir_q      <= 2'(3 - int'(key_idx));
                    end
                end
                S_ERROR: begin
                    if (err_cnt == '0) begin
                        err_q <= 1'b0;
                        st    <= S_IDLE;
                    end else begin
                        err_cnt <= err_cnt - 1'b1;
                    end
                end
                S_END: begin
                    st <= S_START;
                end
                default: begin
                    st <= S_START;
                end
            endcase
        end
    end

    assign bus.state        = st;
    assign bus.barcode_push = barcode_push_q;
    assign bus.digit_out    = digit_q;
    assign bus.barcode_clr  = barcode_clr_q;
    assign bus.dir_push     = dir_push_q;
    assign bus.dir_out      = dir_q;
    assign bus.basket_add   = basket_add_q;
    assign bus.basket_del   = basket_del_q;
    assign bus.pid_out      = pid_q;
    assign bus.qty_out      = qty_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_sale_terminal_fsm.sv
// Bench for sale_terminal_fsm: randomized key/pid/count stimulus checked
// against expectations derived from the terminal's rules.
module tb_sale_terminal_fsm;
    localparam int NK = 4;
    localparam int DW = 4;
    localparam int PW = 4;
    localparam int BD = 8;
    localparam int MQ = 9;
    localparam int EH = 10;
    localparam int QT = 20;
    localparam int CW = $clog2(BD + 1);

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    sale_terminal_if #(.NUM_KEYS(NK), .DIGIT_W(DW), .PID_W(PW), .CNT_W(CW)) bus ();

    sale_terminal_fsm #(
        .NUM_KEYS(NK), .DIGIT_W(DW), .PID_W(PW), .BASKET_DEPTH(BD),
        .MAX_QTY(MQ), .ERR_HOLD(EH), .QTY_TIMEOUT(QT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus)
    );

    // Direction code per key index: right, down, up, left.
    logic [1:0] dir_tab [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

    function automatic int lsb_idx(input logic [NK-1:0] v);
        for (int j = 0; j < NK; j++) if (v[j]) return j;
        return -1;
    endfunction

    // Random key vector whose lowest set bit is i.
    function automatic logic [NK-1:0] key_vec(input int i);
        logic [NK-1:0] r;
        r = NK'($urandom);
        r = r | (NK'(1) << i);
        r = r & ~((NK'(1) << i) - NK'(1));
        return r;
    endfunction

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit);
        int n;
        n = 0;
        while (bus.state !== s && n < limit) begin
            tick;
            n++;
        end
        if (bus.state !== s) begin
            total++;
            bad++;
            $display("FAIL wait_state: state=%0d required=%0d", bus.state, s);
        end
    endtask

    task automatic enter_qty_barcode(input logic [PW-1:0] pid);
        wait_state(3'd2, 6);
        bus.barcode_done  = 1'b1;
        bus.barcode_valid = 1'b1;
        bus.barcode_pid   = pid;
        bus.sel_pulse     = 1'b1;
        tick;
        bus.sel_pulse     = 1'b0;
        bus.barcode_done  = 1'b0;
        bus.barcode_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (bus.state !== 3'd0 || {bus.barcode_push, bus.digit_out, bus.barcode_clr, bus.dir_push,
             bus.dir_out, bus.basket_add, bus.basket_del, bus.pid_out, bus.qty_out, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: state=%0d push=%b clr=%b err=%b required all zero",
                     bus.state, bus.barcode_push, bus.barcode_clr, bus.err);
        end
        #1 RESET_N = 1'b1;
        tick;
        total++;
        if (bus.state !== 3'd1 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL start_to_idle: state=%0d clr=%b required state=1 clr=1", bus.state, bus.barcode_clr);
        end
        tick;
        total++;
        if (bus.state !== 3'd2 || bus.barcode_clr !== 1'b0) begin
            bad++;
            $display("FAIL idle_to_barcode: state=%0d clr=%b required state=2 clr=0", bus.state, bus.barcode_clr);
        end
    endtask

    task automatic test_barcode;
        logic [NK-1:0] kv;
        for (int i = 3; i >= 0; i--) begin
            kv = key_vec(i);
            bus.key_pulse = kv;
            tick;
            bus.key_pulse = '0;
            total++;
            if (bus.barcode_push !== 1'b1 || bus.digit_out !== DW'(NK - lsb_idx(kv))) begin
                bad++;
                $display("FAIL barcode_digit: push=%b digit=%0d required push=1 digit=%0d",
                         bus.barcode_push, bus.digit_out, NK - lsb_idx(kv));
            end
            tick;
            total++;
            if (bus.barcode_push !== 1'b0) begin
                bad++;
                $display("FAIL barcode_push_width: push=%b required 0", bus.barcode_push);
            end
        end
        bus.barcode_done  = 1'b1;
        bus.barcode_valid = 1'b1;
        bus.barcode_pid   = 4'd5;
        bus.key_pulse     = key_vec($urandom_range(0, NK - 1));
        tick;
        bus.key_pulse = '0;
        total++;
        if (bus.barcode_push !== 1'b0) begin
            bad++;
            $display("FAIL barcode_key_after_done: push=%b required 0", bus.barcode_push);
        end
        bus.sel_pulse = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.state !== 3'd4 || bus.pid_out !== 4'd5 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL barcode_select: state=%0d pid=%0d clr=%b required state=4 pid=5 clr=1",
                     bus.state, bus.pid_out, bus.barcode_clr);
        end
        bus.barcode_done  = 1'b0;
        bus.barcode_valid = 1'b0;
        tick;
        total++;
        if (bus.barcode_clr !== 1'b0 || bus.state !== 3'd4) begin
            bad++;
            $display("FAIL barcode_clr_once: clr=%b state=%0d required clr=0 state=4", bus.barcode_clr, bus.state);
        end
    endtask

    task automatic test_quantity;
        logic [NK-1:0] kv;
        logic [PW-1:0] pid;
        int sum, exp_q, nk;
        for (int k = 0; k < 3; k++) begin
            bus.key_pulse = key_vec(3);
            tick;
            bus.key_pulse = '0;
        end
        bus.basket_count = CW'(2);
        bus.sel_pulse    = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.basket_add !== 1'b1 || bus.qty_out !== DW'(9) || bus.state !== 3'd1) begin
            bad++;
            $display("FAIL qty_saturate: add=%b qty=%0d state=%0d required add=1 qty=9 state=1",
                     bus.basket_add, bus.qty_out, bus.state);
        end
        for (int r = 0; r < 4; r++) begin
            pid = PW'($urandom);
            enter_qty_barcode(pid);
            nk  = $urandom_range(1, 4);
            sum = 0;
            for (int k = 0; k < nk; k++) begin
                kv = key_vec($urandom_range(0, NK - 1));
                sum += lsb_idx(kv) + 1;
                bus.key_pulse = kv;
                tick;
                bus.key_pulse = '0;
            end
            exp_q = (sum > MQ) ? MQ : sum;
            bus.basket_count = CW'($urandom_range(0, BD - 1));
            bus.sel_pulse    = 1'b1;
            tick;
            bus.sel_pulse = 1'b0;
            total++;
            if (bus.basket_add !== 1'b1 || bus.qty_out !== DW'(exp_q) || bus.pid_out !== pid || bus.state !== 3'd1) begin
                bad++;
                $display("FAIL qty_random: add=%b qty=%0d pid=%0d state=%0d required add=1 qty=%0d pid=%0d state=1",
                         bus.basket_add, bus.qty_out, bus.pid_out, bus.state, exp_q, pid);
            end
        end
        bus.basket_count = '0;
    endtask

    task automatic test_error;
        int n;
        wait_state(3'd2, 6);
        bus.barcode_done  = 1'b1;
        bus.barcode_valid = 1'b0;
        bus.sel_pulse     = 1'b1;
        tick;
        bus.sel_pulse    = 1'b0;
        bus.barcode_done = 1'b0;
        total++;
        if (bus.state !== 3'd6 || bus.err !== 1'b1 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL error_entry: state=%0d err=%b clr=%b required state=6 err=1 clr=1",
                     bus.state, bus.err, bus.barcode_clr);
        end
        n = 1;
        while (bus.err === 1'b1 && n < 40) begin
            bus.key_pulse = NK'($urandom);
            bus.sel_pulse = 1'($urandom);
            tick;
            if (bus.err === 1'b1) n++;
        end
        bus.key_pulse = '0;
        bus.sel_pulse = 1'b0;
        total++;
        if (n !== EH || bus.state !== 3'd1) begin
            bad++;
            $display("FAIL error_hold: cycles=%0d state=%0d required cycles=%0d state=1", n, bus.state, EH);
        end
    endtask

    task automatic test_interactive;
        logic [NK-1:0] kv;
        bus.sw_interactive = 1'b1;
        tick;
        total++;
        if (bus.state !== 3'd3 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL inter_entry: state=%0d clr=%b required state=3 clr=1", bus.state, bus.barcode_clr);
        end
        for (int k = 0; k < 4; k++) begin
            kv = key_vec((k == 0) ? 0 : $urandom_range(0, 3));
            bus.key_pulse = kv;
            tick;
            bus.key_pulse = '0;
            total++;
            if (bus.dir_push !== 1'b1 || bus.dir_out !== dir_tab[lsb_idx(kv)]) begin
                bad++;
                $display("FAIL inter_dir: push=%b dir=%b required push=1 dir=%b",
                         bus.dir_push, bus.dir_out, dir_tab[lsb_idx(kv)]);
            end
        end
        bus.dir_pid   = 4'd7;
        bus.sel_pulse = 1'b1;
        bus.key_pulse = key_vec(2);
        tick;
        bus.sel_pulse = 1'b0;
        bus.key_pulse = '0;
        total++;
        if (bus.state !== 3'd4 || bus.pid_out !== 4'd7 || bus.dir_push !== 1'b0) begin
            bad++;
            $display("FAIL inter_select: state=%0d pid=%0d push=%b required state=4 pid=7 push=0",
                     bus.state, bus.pid_out, bus.dir_push);
        end
        bus.sel_pulse = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.state !== 3'd4 || bus.basket_add !== 1'b0) begin
            bad++;
            $display("FAIL qty_zero_sel: state=%0d add=%b required state=4 add=0", bus.state, bus.basket_add);
        end
        bus.key_pulse = key_vec(1);
        tick;
        bus.key_pulse    = '0;
        bus.basket_count = CW'(BD);
        bus.sel_pulse    = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.state !== 3'd6 || bus.basket_add !== 1'b0 || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL basket_full: state=%0d add=%b err=%b required state=6 add=0 err=1",
                     bus.state, bus.basket_add, bus.err);
        end
        bus.sw_interactive = 1'b0;
        bus.basket_count   = '0;
        wait_state(3'd1, EH + 5);
    endtask

    task automatic test_edit;
        bus.sw_edit = 1'b1;
        tick;
        total++;
        if (bus.state !== 3'd5 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL edit_entry: state=%0d clr=%b required state=5 clr=1", bus.state, bus.barcode_clr);
        end
        bus.basket_count = '0;
        bus.sel_pulse    = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.basket_del !== 1'b0) begin
            bad++;
            $display("FAIL edit_empty_del: del=%b required 0", bus.basket_del);
        end
        bus.basket_count = CW'(3);
        bus.sel_pulse    = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.basket_del !== 1'b1) begin
            bad++;
            $display("FAIL edit_del: del=%b required 1", bus.basket_del);
        end
        bus.key_pulse = key_vec(3);
        tick;
        bus.key_pulse = '0;
        total++;
        if (bus.basket_del !== 1'b0 || bus.dir_push !== 1'b1 || bus.dir_out !== 2'b00) begin
            bad++;
            $display("FAIL edit_dir: del=%b push=%b dir=%b required del=0 push=1 dir=00",
                     bus.basket_del, bus.dir_push, bus.dir_out);
        end
        bus.sw_edit = 1'b0;
        tick;
        total++;
        if (bus.state !== 3'd1) begin
            bad++;
            $display("FAIL edit_exit: state=%0d required 1", bus.state);
        end
        bus.sw_edit = 1'b1;
        tick;
        bus.key_pulse = key_vec(0);
        tick;
        bus.key_pulse = '0;
        #1 RESET_N = 1'b0;
        #1;
        total++;
        if (bus.state !== 3'd0 || {bus.barcode_push, bus.digit_out, bus.barcode_clr, bus.dir_push,
             bus.dir_out, bus.basket_add, bus.basket_del, bus.pid_out, bus.qty_out, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_mid_edit: state=%0d push=%b dir=%b pid=%0d required all zero",
                     bus.state, bus.dir_push, bus.dir_out, bus.pid_out);
        end
        bus.sw_edit      = 1'b0;
        bus.basket_count = '0;
        #1 RESET_N = 1'b1;
        tick;
    endtask

    task automatic test_end;
        wait_state(3'd1, 4);
        bus.sel_pulse = 1'b1;
        tick;
        bus.sel_pulse = 1'b0;
        total++;
        if (bus.state !== 3'd7) begin
            bad++;
            $display("FAIL end_state: state=%0d required 7", bus.state);
        end
        tick;
        total++;
        if (bus.state !== 3'd0) begin
            bad++;
            $display("FAIL end_to_start: state=%0d required 0", bus.state);
        end
        tick;
        total++;
        if (bus.state !== 3'd1 || bus.barcode_clr !== 1'b1) begin
            bad++;
            $display("FAIL restart_clr: state=%0d clr=%b required state=1 clr=1", bus.state, bus.barcode_clr);
        end
    endtask

`ifdef SALE_FSM_QTY_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        enter_qty_barcode(PW'($urandom));
        for (int k = 0; k < 15; k++) tick;
        total++;
        if (bus.state !== 3'd4) begin
            bad++;
            $display("FAIL timeout_early: state=%0d required 4", bus.state);
        end
        bus.key_pulse = key_vec(0);
        tick;
        bus.key_pulse = '0;
        n = 0;
        while (bus.state === 3'd4 && n < 40) begin
            tick;
            n++;
        end
        total++;
        if (n !== QT || bus.state !== 3'd1 || bus.barcode_clr !== 1'b1 || bus.basket_add !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: idle=%0d state=%0d clr=%b add=%b required idle=%0d state=1 clr=1 add=0",
                     n, bus.state, bus.barcode_clr, bus.basket_add, QT);
        end
    endtask
`endif

    initial begin
        bus.key_pulse      = '0;
        bus.sel_pulse      = 1'b0;
        bus.sw_interactive = 1'b0;
        bus.sw_edit        = 1'b0;
        bus.barcode_done   = 1'b0;
        bus.barcode_valid  = 1'b0;
        bus.barcode_pid    = '0;
        bus.dir_pid        = '0;
        bus.basket_count   = '0;
        test_reset;
        test_barcode;
        test_quantity;
        test_error;
        test_interactive;
        test_edit;
        test_end;
`ifdef SALE_FSM_QTY_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sale_terminal_fsm.md
Name: sale_terminal_fsm

Overview:
Parametrised successor to the terminal's top-level control FSM. It sequences barcode entry, interactive selection, quantity entry, basket edit and end-of-shopping. Unlike the previous generation it supports:
- configurable key count and barcode length;
- accumulated quantity with saturation and explicit commit;
- basket-full rejection;
- a timed error state.

It sits between the button/switch conditioners and the barcode, direction and basket controllers. All commands it issues are single-cycle pulses.

Parameters:
NUM_KEYS, 4, number of digit/direction keys (2..8)
DIGIT_W, 4, width of a barcode digit and of qty_out
PID_W, 4, product ID width
BASKET_DEPTH, 8, maximum basket entries; count width CNT_W = clog2(BASKET_DEPTH+1)
MAX_QTY, 9, saturation value for accumulated quantity (1..2^DIGIT_W-1)
ERR_HOLD, 50000000, cycles spent in ERROR (≥1)
QTY_TIMEOUT, 500000000, idle cycles before quantity entry aborts (used only with the optional feature)

Ports:
CLOCK_50  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
key_pulse  in  NUM_KEYS  one-cycle key press pulses
sel_pulse  in  1  one-cycle Select press
sw_interactive  in  1  debounced SW1 level
sw_edit  in  1  debounced SW2 level
barcode_done  in  1  barcode register holds all digits
barcode_valid  in  1  completed barcode maps to a product
barcode_pid  in  PID_W  product ID from barcode lookup
dir_pid  in  PID_W  product ID under interactive cursor
basket_count  in  CNT_W  entries currently in basket
state  out  3  current state code (to LED controller)
barcode_push  out  1  pulse: shift digit_out into barcode register
digit_out  out  DIGIT_W  digit accompanying barcode_push
barcode_clr  out  1  pulse: clear barcode register
dir_push  out  1  pulse: move cursor by dir_out
dir_out  out  2  00 left, 01 up, 10 down, 11 right
basket_add  out  1  pulse: append pid_out × qty_out
basket_del  out  1  pulse: remove entry under cursor (edit mode)
pid_out  out  PID_W  product latched for add
qty_out  out  DIGIT_W  committed quantity
err  out  1  high while in ERROR

Behaviour:
- Reset (async assert, sync deassert) → state START.
- On reset all outputs are 0, except state=0.
- Registered outputs; each pulse output is high exactly one cycle after its triggering input cycle.
- Key decode: the lowest set bit of key_pulse wins (index i).
  - Barcode digit = NUM_KEYS−i.
  - Direction: i=0→11, i=1→10, i=2→01, i=3→00; i≥4 is ignored in INTERACTIVE and EDIT.
  - Quantity increment = i+1.
- START (0): pulse barcode_clr; go to IDLE.
- IDLE (1), priority order:
  - sel_pulse → END.
  - sw_edit → EDIT + barcode_clr.
  - sw_interactive → INTERACTIVE + barcode_clr.
  - otherwise → BARCODE.
- BARCODE (2):
  - sw_interactive|sw_edit → IDLE.
  - !barcode_done & key → barcode_push with digit.
  - barcode_done & sel_pulse & valid → latch pid_out=barcode_pid, barcode_clr, → QUANTITY.
  - barcode_done & sel_pulse & !valid → barcode_clr, → ERROR.
  - Keys are ignored once barcode_done is set.
- INTERACTIVE (3):
  - !sw_interactive → IDLE.
  - sel_pulse → latch pid_out=dir_pid, → QUANTITY.
  - key → dir_push.
  - When sel and a key arrive in the same cycle, sel wins.
- QUANTITY (4): accumulator acc (DIGIT_W) is cleared on entry.
  - key → acc = min(acc+i+1, MAX_QTY).
  - sel_pulse & acc==0 → ignored.
  - sel_pulse & acc>0 & basket_count<BASKET_DEPTH → qty_out=acc, basket_add, → IDLE.
  - sel_pulse & basket_count==BASKET_DEPTH → ERROR; no basket_add.
  - Switches are ignored in this state.
- EDIT (5):
  - !sw_edit → IDLE.
  - sel_pulse & basket_count>0 → basket_del.
  - sel_pulse & basket_count==0 → no pulse.
  - key → dir_push.
- ERROR (6): err=1; down-counter loads ERR_HOLD−1 on entry; at zero → IDLE. All inputs are ignored.
- END (7): → START next cycle.
- Reset mid-operation aborts any state; pulses are never generated during reset.

Optional Feature:
Macro SALE_FSM_QTY_TIMEOUT_EN.
- Defined: a counter (clog2(QTY_TIMEOUT+1) bits) runs in QUANTITY and resets on every key_pulse or sel_pulse. When it reaches QTY_TIMEOUT: pulse barcode_clr, go to IDLE, no basket_add.
- Undefined: QUANTITY waits indefinitely; the counter logic and the QTY_TIMEOUT parameter are unused.

Test Plan:
- Reset, release; barcode keys i=3,2,1,0 → digit_out 1,2,3,4 with four barcode_push pulses. Then barcode_done=1, valid=1, pid=5, sel → QUANTITY, pid_out=5, one barcode_clr.
- QUANTITY with MAX_QTY=9: keys i=3,3,3 → acc 4,8,9 (saturates). Then sel with basket_count=2 → basket_add with qty_out=9, state=1.
- Invalid barcode + sel → ERROR with err=1 for exactly ERR_HOLD cycles (set to 10 in bench), then IDLE.
- sw_interactive=1: key i=0 → dir_push with dir_out=11. Then sel with dir_pid=7 → pid_out=7, QUANTITY. sel with acc=0 is ignored; key i=1 then sel with basket_count=BASKET_DEPTH → ERROR, no basket_add.
- sw_edit=1, basket_count=0, sel → no basket_del. basket_count=3, sel → one basket_del. Drop sw_edit → IDLE. Assert RESET_N low mid-EDIT → all outputs 0 immediately.
- With SALE_FSM_QTY_TIMEOUT_EN and QTY_TIMEOUT=20: enter QUANTITY, no input for 20 cycles → barcode_clr, state=1, no basket_add; a key at cycle 15 restarts the count.
